// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I sequencer: owns pc/instr and walks each instruction through
// FETCH, DECODE, EXECUTE, MEM and WRITEBACK using decoder flags and the ALU result.
module multicycle_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    input  logic        dec_mem_read,
    input  logic        dec_mem_write,
    input  logic        dec_reg_write,
    input  logic        dec_is_jal,
    input  logic        dec_is_jalr,
    input  logic [31:0] dec_imm_j,
    input  logic [31:0] alu_result,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    input  logic        dmem_ready,
    output logic        rf_we,
    output logic [1:0]  wb_src,
    output logic [31:0] link_addr,
    output logic [31:0] pc,
    output logic [2:0]  state,
    output logic        fault,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] npc_q, npc_d;
    logic [31:0] daddr_q, daddr_d;
    logic [31:0] instret_q, instret_d;
    logic        load_q, load_d;
    logic        store_q, store_d;
    logic        link_q, link_d;
    logic        fault_q, fault_d;

    logic        exec_nop;
    logic        exec_link;
    logic        exec_load;
    logic        exec_store;
    logic        exec_rw;
    logic [31:0] exec_npc;

    // An all-zero instruction word overrides whatever the decoder reports.
    always_comb begin
        exec_nop   = (instr_q == 32'h0);
        exec_link  = !exec_nop && (dec_is_jal || dec_is_jalr);
        exec_load  = !exec_nop && dec_mem_read;
        exec_store = !exec_nop && dec_mem_write;
        exec_rw    = !exec_nop && dec_reg_write;
        if (exec_nop) begin
            exec_npc = pc_q + 32'd4;
        end else if (dec_is_jal) begin
            exec_npc = pc_q + dec_imm_j;
        end else if (dec_is_jalr) begin
            exec_npc = {alu_result[31:1], 1'b0};
        end else begin
            exec_npc = pc_q + 32'd4;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        npc_d     = npc_q;
        daddr_d   = daddr_q;
        instret_d = instret_q;
        load_d    = load_q;
        store_d   = store_q;
        link_d    = link_q;
        fault_d   = fault_q;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        rf_we     = 1'b0;
        wb_src    = 2'd0;

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                npc_d   = exec_npc;
                daddr_d = alu_result;
                load_d  = exec_load;
                store_d = exec_store;
                link_d  = exec_link;
                if (exec_link && exec_npc[1]) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end else if (exec_load || exec_store) begin
                    state_d = S_MEM;
                end else if (exec_rw || exec_link) begin
                    state_d = S_WRITEBACK;
                end else begin
                    pc_d      = exec_npc;
                    instret_d = instret_q + 32'd1;
                    state_d   = S_FETCH;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = store_q;
                if (dmem_ready) begin
                    if (store_q) begin
                        pc_d      = npc_q;
                        instret_d = instret_q + 32'd1;
                        state_d   = S_FETCH;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end
            end
            S_WRITEBACK: begin
                rf_we     = 1'b1;
                wb_src    = link_q ? 2'd2 : (load_q ? 2'd1 : 2'd0);
                pc_d      = npc_q;
                instret_d = instret_q + 32'd1;
                state_d   = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            instr_q   <= 32'h0;
            npc_q     <= 32'h0;
            daddr_q   <= 32'h0;
            instret_q <= 32'h0;
            load_q    <= 1'b0;
            store_q   <= 1'b0;
            link_q    <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            npc_q     <= npc_d;
            daddr_q   <= daddr_d;
            instret_q <= instret_d;
            load_q    <= load_d;
            store_q   <= store_d;
            link_q    <= link_d;
            fault_q   <= fault_d;
        end
    end

    // pc only advances on retire, so pc+4 is still the link value in WRITEBACK.
    assign imem_addr = pc_q;
    assign dmem_addr = daddr_q;
    assign link_addr = pc_q + 32'd4;
    assign pc        = pc_q;
    assign instr     = instr_q;
    assign state     = state_q;
    assign fault     = fault_q;
    assign instret   = instret_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: directed scenarios plus randomized instructions
// checked against an instruction-level reference model (latency, pc, retire, writeback).
module tb_multicycle_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        dec_mem_read, dec_mem_write, dec_reg_write, dec_is_jal, dec_is_jalr;
    logic [31:0] dec_imm_j;
    logic [31:0] alu_result;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic        dmem_ready;
    logic        rf_we;
    logic [1:0]  wb_src;
    logic [31:0] link_addr, pc;
    logic [2:0]  state;
    logic        fault;
    logic [31:0] instret;

    always #5 clk = ~clk;

    multicycle_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr(instr),
        .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write), .dec_reg_write(dec_reg_write),
        .dec_is_jal(dec_is_jal), .dec_is_jalr(dec_is_jalr), .dec_imm_j(dec_imm_j),
        .alu_result(alu_result),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_ready(dmem_ready),
        .rf_we(rf_we), .wb_src(wb_src), .link_addr(link_addr), .pc(pc), .state(state),
        .fault(fault), .instret(instret)
    );

    localparam int C_NOP = 0, C_ALU = 1, C_ALUNW = 2, C_LOAD = 3, C_STORE = 4, C_JAL = 5, C_JALR = 6;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_pc;
    logic [31:0] m_instret;
    logic        m_fault;
    logic [11:0] last_seq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one instruction (bench acts as memories and decoder) and checks it
    // against the reference model's view of what that instruction must do.
    task automatic run_instr(input int cls, input logic [31:0] iw, input logic [31:0] imm,
                             input logic [31:0] alu, input int iwait, input int dwait);
        logic [31:0] e_npc, old_pc, iw_eff, lnk;
        logic        e_fault, e_rf, e_mem;
        logic [1:0]  e_wbs, wbs;
        int          e_cyc, cyc, rf_cnt, ireq, dreq;
        logic        ibad, dbad, left, done;

        iw_eff     = (cls == C_NOP) ? 32'h0 : iw;
        imem_rdata = iw_eff;
        if (cls == C_NOP) begin
            {dec_mem_read, dec_mem_write, dec_reg_write, dec_is_jal, dec_is_jalr} = 5'($urandom);
        end else begin
            dec_mem_read  = (cls == C_LOAD);
            dec_mem_write = (cls == C_STORE);
            dec_reg_write = (cls == C_ALU) || (cls == C_LOAD) || (cls == C_JAL) || (cls == C_JALR);
            dec_is_jal    = (cls == C_JAL);
            dec_is_jalr   = (cls == C_JALR);
        end
        dec_imm_j  = imm;
        alu_result = alu;

        old_pc = m_pc;
        case (cls)
            C_JAL:   e_npc = m_pc + imm;
            C_JALR:  e_npc = alu & 32'hFFFF_FFFE;
            default: e_npc = m_pc + 32'd4;
        endcase
        e_fault = ((cls == C_JAL) || (cls == C_JALR)) && e_npc[1];
        e_rf    = !e_fault && ((cls == C_ALU) || (cls == C_LOAD) || (cls == C_JAL) || (cls == C_JALR));
        e_mem   = (cls == C_LOAD) || (cls == C_STORE);
        e_wbs   = ((cls == C_JAL) || (cls == C_JALR)) ? 2'd2 : ((cls == C_LOAD) ? 2'd1 : 2'd0);
        e_cyc   = iwait + 3 + (e_mem ? dwait + 1 : 0) + (e_rf ? 1 : 0);

        cyc = 0; rf_cnt = 0; ireq = 0; dreq = 0;
        ibad = 0; dbad = 0; left = 0; done = 0;
        wbs = 2'd0; lnk = 32'h0; last_seq = 12'h0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            if (imem_req) begin
                ireq++;
                if (imem_addr !== old_pc) ibad = 1;
                imem_ready = (ireq > iwait);
            end else begin
                imem_ready = 1'($urandom_range(0, 1));
            end
            if (dmem_req) begin
                dreq++;
                if (dmem_addr !== alu || dmem_we !== (cls == C_STORE)) dbad = 1;
                dmem_ready = (dreq > dwait);
            end else begin
                dmem_ready = 1'($urandom_range(0, 1));
            end
            if (rf_we) begin
                rf_cnt++;
                wbs = wb_src;
                lnk = link_addr;
            end
            @(posedge clk);
            #1;
            cyc++;
            last_seq = {last_seq[8:0], state};
            if (state == 3'd5) done = 1;
            else if (state != 3'd0) left = 1;
            else if (left) done = 1;
        end

        chk("completed", 32'(done), 32'd1);
        chk("cycles", cyc, e_cyc);
        chk("instr", instr, iw_eff);
        chk("rf_we_pulses", rf_cnt, 32'(e_rf));
        if (e_rf) begin
            chk("wb_src", 32'(wbs), 32'(e_wbs));
            chk("link_addr", lnk, old_pc + 32'd4);
        end
        chk("imem_req_cycles", ireq, iwait + 1);
        chk("imem_addr_stable", 32'(ibad), 32'd0);
        chk("dmem_req_cycles", dreq, e_mem ? dwait + 1 : 0);
        chk("dmem_addr_we", 32'(dbad), 32'd0);

        if (e_fault) begin
            m_fault = 1'b1;
        end else begin
            m_pc      = e_npc;
            m_instret = m_instret + 32'd1;
        end
        chk("pc", pc, m_pc);
        chk("next_imem_addr", imem_addr, m_pc);
        chk("instret", instret, m_instret);
        chk("fault", 32'(fault), 32'(m_fault));
        chk("state_after", 32'(state), m_fault ? 32'd5 : 32'd0);
        $display("instr cls=%0d iw=%h pc %h->%h cycles=%0d instret=%0d", cls, iw_eff, old_pc, pc, cyc, instret);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_pc"}, pc, 32'h0);
        chk({tag, "_imem_addr"}, imem_addr, 32'h0);
        chk({tag, "_instr"}, instr, 32'h0);
        chk({tag, "_instret"}, instret, 32'h0);
        chk({tag, "_fault"}, 32'(fault), 32'd0);
        chk({tag, "_imem_req"}, 32'(imem_req), 32'd1);
        chk({tag, "_dmem_req"}, 32'(dmem_req), 32'd0);
        chk({tag, "_dmem_we"}, 32'(dmem_we), 32'd0);
        chk({tag, "_rf_we"}, 32'(rf_we), 32'd0);
        chk({tag, "_wb_src"}, 32'(wb_src), 32'd0);
        chk({tag, "_link_addr"}, link_addr, 32'h4);
    endtask

    initial begin
        int          cls, iw_w, dw_w, cnt;
        logic [31:0] imm, alu;

        rst_n = 1'b0;
        imem_ready = 1'b0; imem_rdata = 32'h0;
        {dec_mem_read, dec_mem_write, dec_reg_write, dec_is_jal, dec_is_jalr} = 5'h0;
        dec_imm_j = 32'h0; alu_result = 32'h0; dmem_ready = 1'b0;
        m_pc = 32'h0; m_instret = 32'h0; m_fault = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("fetch_after_release", imem_addr, 32'h0);

        // ADDI x1,x0,5 with zero-wait memories
        run_instr(C_ALU, 32'h0050_0093, 32'h0, 32'h5, 0, 0);
        chk("addi_state_seq", 32'(last_seq), 32'h2A0);

        // LW with dmem_ready delayed 3 cycles
        run_instr(C_LOAD, 32'h0000_A103, 32'h0, 32'h0000_1234, 0, 3);

        // reach pc 0x100, then JAL +0x10
        run_instr(C_JAL, 32'h0000_006F, 32'h100 - m_pc, 32'h0, 0, 0);
        run_instr(C_JAL, 32'h0100_00EF, 32'h0000_0010, 32'h0, 1, 0);

        // pc wrap: land on 0xFFFF_FFFC, then a NOP wraps to 0
        run_instr(C_JAL, 32'h0000_006F, 32'hFFFF_FFFC - m_pc, 32'h0, 0, 0);
        run_instr(C_NOP, 32'h0, 32'h0, 32'h0, 0, 0);

        // store, NOP and non-writing ALU op with waits
        run_instr(C_STORE, 32'h0020_A023, 32'h0, 32'h0000_0F00, 2, 1);
        run_instr(C_ALUNW, 32'h0000_0063, 32'h0, 32'h0, 0, 0);

        for (int n = 0; n < 300; n++) begin
            cls  = $urandom_range(0, 6);
            imm  = $urandom & 32'hFFFF_FFFC;
            alu  = $urandom & 32'hFFFF_FFFD;
            iw_w = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            dw_w = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            run_instr(cls, $urandom | 32'h1, imm, alu, iw_w, dw_w);
        end

        // asynchronous reset while a store is waiting in MEM
        imem_rdata = 32'h0020_A023;
        {dec_mem_read, dec_mem_write, dec_reg_write, dec_is_jal, dec_is_jalr} = 5'b01000;
        alu_result = 32'h4000_0010;
        cnt = 0;
        while (state !== 3'd3 && cnt < 20) begin
            @(negedge clk);
            imem_ready = 1'b1;
            dmem_ready = 1'b0;
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("reached_mem", 32'(state), 32'd3);
        @(negedge clk);
        chk("mem_dmem_req", 32'(dmem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_values("async_reset");
        @(posedge clk);
        #1;
        imem_ready = 1'b0;
        dmem_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        m_pc = 32'h0; m_instret = 32'h0; m_fault = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk("post_reset_imem_addr", imem_addr, 32'h0);
            chk("post_reset_rf_we", 32'(rf_we), 32'd0);
        end
        run_instr(C_ALU, 32'h0050_0093, 32'h0, 32'h5, 0, 0);

        // JALR to 0x203: target 0x202 is misaligned, so the core halts
        run_instr(C_JALR, 32'h0000_8067, 32'h0, 32'h0000_0203, 0, 0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            imem_ready = 1'($urandom_range(0, 1));
            dmem_ready = 1'($urandom_range(0, 1));
            chk("halt_imem_req", 32'(imem_req), 32'd0);
            chk("halt_rf_we", 32'(rf_we), 32'd0);
            chk("halt_instret", instret, m_instret);
            chk("halt_pc", pc, m_pc);
        end
        chk("halt_state", 32'(state), 32'd5);

        // reset is the only way out of HALT
        rst_n = 1'b0;
        #1;
        chk_reset_values("halt_reset");
        @(negedge clk);
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle instruction sequencer for the x32 RV32I core. It owns the program counter and instruction register, and walks each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK. It consumes the per-instruction control outputs of the instruction decoder and the ALU result. It drives the instruction-memory port, the data-memory port and the register-file write strobe.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- imem_req  out  1  instruction fetch request
- imem_addr  out  32  fetch address (= pc)
- imem_ready  in  1  fetch data valid this cycle
- imem_rdata  in  32  fetched instruction
- instr  out  32  instruction register, feeds decoder
- dec_mem_read  in  1  decoded load
- dec_mem_write  in  1  decoded store
- dec_reg_write  in  1  decoded register write
- dec_is_jal  in  1  decoded JAL
- dec_is_jalr  in  1  decoded JALR
- dec_imm_j  in  32  sign-extended J-type offset
- alu_result  in  32  ALU output, valid in EXECUTE
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  32  data address
- dmem_ready  in  1  data access complete this cycle
- rf_we  out  1  register-file write strobe
- wb_src  out  2  writeback select: 0 ALU, 1 memory, 2 link
- link_addr  out  32  pc+4
- pc  out  32  current PC
- state  out  3  FSM state encoding
- fault  out  1  sticky misaligned-jump fault
- instret  out  32  retired-instruction counter

## Operation
- State encoding:
  - FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, HALT=5.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ready: instr<=imem_rdata, go to DECODE.
- DECODE: one cycle for decoder outputs to settle, then EXECUTE.
- EXECUTE: latch npc, daddr<=alu_result and the decode flags into internal registers. npc is:
  - dec_is_jal: pc+dec_imm_j.
  - dec_is_jalr: alu_result with bit0 cleared.
  - otherwise: pc+4.
- Fault check in EXECUTE:
  - If npc[1]=1 on JAL/JALR: fault<=1, go to HALT. No write, no retire.
- Next state from EXECUTE:
  - Load or store: MEM.
  - Else dec_reg_write or JAL/JALR: WRITEBACK.
  - Else: FETCH and retire.
- MEM:
  - dmem_req=1, dmem_we=latched store flag, dmem_addr=daddr.
  - On dmem_ready: a load goes to WRITEBACK; a store goes to FETCH and retires.
- WRITEBACK:
  - rf_we=1 for exactly one cycle.
  - wb_src = 2 for JAL/JALR, 1 for load, else 0.
  - Then FETCH and retire.
- Retire: pc<=npc, instret<=instret+1.
- instr==32'h0: treated as NOP. EXECUTE goes straight to FETCH and retires with pc+4.
- HALT: absorbing. All requests and rf_we are 0, pc frozen. Exit only via reset.
- Arithmetic: pc+4, pc+imm and instret are modulo 2^32, so 32'hFFFF_FFFC+4 gives 0.
- Outputs are 0 outside their own states: imem_req outside FETCH, dmem_req/dmem_we outside MEM, rf_we outside WRITEBACK.

## Timing
- Reset values:
  - state=FETCH, pc=RESET_PC, instr=0, instret=0, fault=0.
  - imem_req=1 (FETCH); dmem_req=dmem_we=rf_we=0; wb_src=0.
  - link_addr=RESET_PC+4.
- Request handshake:
  - A request stays high, with address stable, until ready is sampled high on a rising edge.
  - Ready is ignored when the matching req is low.
  - The FSM advances on the same edge that samples ready.
- Latency with zero-wait memories (ready high in the first request cycle):
  - NOP: 3 cycles.
  - ALU op, JAL, JALR: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- Each wait cycle on imem_ready or dmem_ready adds exactly one cycle.
- pc changes only on the retire edge; instret increments on that same edge.
- link_addr is combinational pc+4. It is valid in WRITEBACK because pc has not yet advanced.
- Reset asserted mid-instruction (any state, including a pending request):
  - Immediate return to reset values.
  - The outstanding request is dropped; no retire, no rf_we.
- Fetch restarts at RESET_PC on the first rising edge after rst_n deasserts.

## Test plan
- Zero-wait ADDI x1,x0,5 (32'h0050_0093) at pc 0:
  - state sequence 0,1,2,4,0.
  - rf_we high exactly one cycle with wb_src=0.
  - pc=4, instret=1 after 4 cycles.
- LW with dmem_ready delayed 3 cycles:
  - dmem_req held 4 cycles with dmem_addr stable at alu_result, dmem_we=0.
  - Then WRITEBACK with wb_src=1; total 8 cycles.
- JAL with dec_imm_j=32'h0000_0010 at pc 32'h100:
  - rf_we with wb_src=2, link_addr=32'h104.
  - Next imem_addr=32'h110.
- JALR with alu_result=32'h0000_0203:
  - npc=32'h202, npc[1]=1, so fault=1 and state goes to HALT.
  - imem_req stays 0 and instret is unchanged for 20 cycles.
- PC wrap:
  - NOP at pc 32'hFFFF_FFFC takes 3 cycles and the next imem_addr=0.
  - Separately, an instruction retiring with instret=32'hFFFF_FFFF wraps instret to 0.
- Async reset during MEM with dmem_req=1:
  - All outputs reach reset values before the next edge.
  - After rst_n releases, imem_addr=RESET_PC and no rf_we pulse occurs.
